stack_controller: RTL and testbench

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_controller_if.sv | 43 ++++
 rtl/stack_controller.sv | 126 ++++++++++++
 tb/tb_stack_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_controller_if : request, RAM-port, load and status bundle of the stack
// Revision 1.0
// ----------------------------------------------------------------------------
interface stack_controller_if;
  logic       push_req;
  logic       pop_req;
  logic       call_req;
  logic       ret_req;
  logic [3:0] b_data;
  logic [3:0] pc_data;
  logic [3:0] ram_rdata;
  logic       clear_err;
  logic [3:0] ram_addr;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_wdata;
  logic       b_load;
  logic       pc_load;
  logic [3:0] load_data;
  logic       busy;
  logic       done;
  logic [3:0] sp;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  modport slave (
    input  push_req, pop_req, call_req, ret_req, b_data, pc_data, ram_rdata, clear_err,
    output ram_addr, ram_we, ram_re, ram_wdata, b_load, pc_load, load_data,
           busy, done, sp, count, empty, full, overflow, underflow
  );

  modport master (
    output push_req, pop_req, call_req, ret_req, b_data, pc_data, ram_rdata, clear_err,
    input  ram_addr, ram_we, ram_re, ram_wdata, b_load, pc_load, load_data,
           busy, done, sp, count, empty, full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/stack_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stack_controller : downward-growing push/pop/call/ret stack over a RAM port
// Revision 1.0
// ----------------------------------------------------------------------------
module stack_controller #(
  parameter logic [3:0] STACK_TOP = 4'hF,
  parameter int         DEPTH     = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  stack_controller_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] LD   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [3:0] c_depth = 4'(DEPTH);

  logic [2:0] r_state;
  logic [3:0] r_sp;
  logic [3:0] r_count;
  logic [3:0] r_wdata;
  logic       r_to_pc;
  logic       r_overflow;
  logic       r_underflow;

  logic       w_any;
  logic       w_write;
  logic [3:0] w_wsel;
  logic       w_empty;
  logic       w_full;
  logic       w_ovf_set;
  logic       w_unf_set;

  // Grant priority call > ret > push > pop; losers are simply dropped.
  always_comb begin
    w_any     = bus.call_req | bus.ret_req | bus.push_req | bus.pop_req;
    w_write   = bus.call_req | (~bus.ret_req & bus.push_req);
    w_wsel    = bus.call_req ? bus.pc_data : bus.b_data;
    w_empty   = (r_count == 4'd0);
    w_full    = (r_count == c_depth);
    w_ovf_set = (r_state == IDLE) & w_any & w_write & w_full;
    w_unf_set = (r_state == IDLE) & w_any & ~w_write & w_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sp        <= STACK_TOP;
      r_count     <= 4'd0;
      r_wdata     <= 4'd0;
      r_to_pc     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // A set event outranks a simultaneous clear.
      r_overflow  <= w_ovf_set | (r_overflow & ~bus.clear_err);
      r_underflow <= w_unf_set | (r_underflow & ~bus.clear_err);
      case (r_state)
        IDLE: begin
          if (w_any) begin
            if (w_write) begin
              if (w_full) begin
                r_state <= DONE;
              end else begin
                r_state <= WR;
                r_wdata <= w_wsel;
              end
            end else begin
              if (w_empty) begin
                r_state <= DONE;
              end else begin
                r_state <= RD;
                r_to_pc <= bus.ret_req;
              end
            end
          end
        end
        WR: begin
          r_sp    <= r_sp - 4'd1;
          r_count <= r_count + 4'd1;
          r_state <= DONE;
        end
        RD: begin
          r_state <= LD;
        end
        LD: begin
          r_sp    <= r_sp + 4'd1;
          r_count <= r_count - 4'd1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    bus.ram_we    = (r_state == WR);
    bus.ram_re    = (r_state == RD);
    bus.ram_addr  = (r_state == RD) ? (r_sp + 4'd1) : r_sp;
    bus.ram_wdata = (r_state == WR) ? r_wdata : 4'd0;
    bus.b_load    = (r_state == LD) & ~r_to_pc;
    bus.pc_load   = (r_state == LD) & r_to_pc;
    bus.load_data = (r_state == LD) ? bus.ram_rdata : 4'd0;
    bus.busy      = (r_state != IDLE);
    bus.done      = (r_state == DONE);
    bus.sp        = r_sp;
    bus.count     = r_count;
    bus.empty     = w_empty;
    bus.full      = w_full;
    bus.overflow  = r_overflow;
    bus.underflow = r_underflow;
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stack_controller : randomized self-checking bench against a queue model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_stack_controller;

  localparam int TOP_I = 15;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  stack_controller_if sif ();

  stack_controller #(.STACK_TOP(4'hF), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple RAM: write on we, registered read one cycle after re.
  logic [3:0] mem [16];
  always @(posedge clk) begin
    if (sif.ram_we) mem[sif.ram_addr] <= sif.ram_wdata;
    if (sif.ram_re) sif.ram_rdata <= mem[sif.ram_addr];
  end

  logic [17:0] obs;
  logic [11:0] st;
  assign obs = {sif.ram_we, sif.ram_re, sif.b_load, sif.pc_load, sif.done, sif.busy,
                sif.ram_addr, sif.ram_wdata, sif.load_data};
  assign st  = {sif.sp, sif.count, sif.empty, sif.full, sif.overflow, sif.underflow};

  // Reference model: stack contents and sticky flags only.
  logic [3:0] stk [$];
  bit         ovf_m;
  bit         unf_m;

  function automatic logic [11:0] model_status();
    logic [3:0] msp;
    msp = 4'(TOP_I - stk.size());
    return {msp, 4'(stk.size()), stk.size() == 0, stk.size() == DEPTH, ovf_m, unf_m};
  endfunction

  task automatic clear_inputs();
    sif.push_req  = 1'b0;
    sif.pop_req   = 1'b0;
    sif.call_req  = 1'b0;
    sif.ret_req   = 1'b0;
    sif.clear_err = 1'b0;
  endtask

  task automatic junk_reqs();
    sif.push_req = 1'($urandom % 2);
    sif.pop_req  = 1'($urandom % 2);
    sif.call_req = 1'($urandom % 2);
    sif.ret_req  = 1'($urandom % 2);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    sif.b_data  = 4'h0;
    sif.pc_data = 4'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
  endtask

  // Issues one request set at the next edge and follows the whole operation.
  task automatic run_op(input string tag, input bit c, input bit r, input bit p, input bit o,
                        input logic [3:0] bd, input logic [3:0] pd, input bit clr);
    bit          any_op, wr_op;
    logic [3:0]  wd, msp, top;
    logic [17:0] exp_obs;
    any_op = c | r | p | o;
    wr_op  = c | (!r & p);
    wd     = c ? pd : bd;
    msp    = 4'(TOP_I - stk.size());
    sif.call_req = c; sif.ret_req = r; sif.push_req = p; sif.pop_req = o;
    sif.b_data = bd; sif.pc_data = pd; sif.clear_err = clr;
    ovf_m = (any_op && wr_op && stk.size() == DEPTH) || (ovf_m && !clr);
    unf_m = (any_op && !wr_op && stk.size() == 0) || (unf_m && !clr);
    @(negedge clk);
    clear_inputs();
    if (!any_op) begin
      exp_obs = {6'b0, msp, 8'h00};
    end else if (wr_op && stk.size() == DEPTH || !wr_op && stk.size() == 0) begin
      exp_obs = {4'b0000, 1'b1, 1'b1, msp, 8'h00};
    end else if (wr_op) begin
      junk_reqs();
      exp_obs = {6'b100001, msp, wd, 4'h0};
    end else begin
      junk_reqs();
      exp_obs = {6'b010001, 4'(msp + 4'd1), 8'h00};
    end
    checks++;
    if (obs !== exp_obs) begin
      failures++;
      $display("FAIL %s cycle1 bus: got %h expected %h", tag, obs, exp_obs);
    end
    checks++;
    if (st !== model_status()) begin
      failures++;
      $display("FAIL %s cycle1 status: got %h expected %h", tag, st, model_status());
    end
    if (any_op && !(wr_op && stk.size() == DEPTH) && !(!wr_op && stk.size() == 0)) begin
      if (!wr_op) begin
        @(negedge clk);
        top = stk[$];
        exp_obs = {2'b00, !r, r, 2'b01, msp, 4'h0, top};
        checks++;
        if (obs !== exp_obs) begin
          failures++;
          $display("FAIL %s load bus: got %h expected %h", tag, obs, exp_obs);
        end
        void'(stk.pop_back());
      end else begin
        stk.push_back(wd);
      end
      @(negedge clk);
      clear_inputs();
      msp = 4'(TOP_I - stk.size());
      exp_obs = {6'b000011, msp, 8'h00};
      checks++;
      if (obs !== exp_obs) begin
        failures++;
        $display("FAIL %s done bus: got %h expected %h", tag, obs, exp_obs);
      end
      checks++;
      if (st !== model_status()) begin
        failures++;
        $display("FAIL %s done status: got %h expected %h", tag, st, model_status());
      end
    end
    if (any_op) begin
      @(negedge clk);
      exp_obs = {6'b0, msp, 8'h00};
      checks++;
      if (obs !== exp_obs) begin
        failures++;
        $display("FAIL %s idle bus: got %h expected %h", tag, obs, exp_obs);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (obs !== {6'b0, 4'hF, 8'h00}) begin
      failures++;
      $display("FAIL reset bus: got %h expected %h", obs, {6'b0, 4'hF, 8'h00});
    end
    checks++;
    if (st !== 12'hF0_8) begin
      failures++;
      $display("FAIL reset status: got %h expected %h", st, 12'hF08);
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    run_op("push_a", 0, 0, 1, 0, 4'hA, 4'h0, 0);
    checks++;
    if (mem[4'hF] !== 4'hA) begin
      failures++;
      $display("FAIL push_a ram: got %h expected %h", mem[4'hF], 4'hA);
    end
    run_op("pop_a", 0, 0, 0, 1, 4'h0, 4'h0, 0);
  endtask

  task automatic test_priority();
    apply_reset();
    run_op("call_vs_push", 1, 0, 1, 0, 4'hC, 4'h3, 0);
    checks++;
    if ({mem[4'hF], sif.count} !== {4'h3, 4'd1}) begin
      failures++;
      $display("FAIL call_vs_push: got %h expected %h", {mem[4'hF], sif.count}, 8'h31);
    end
    run_op("ret_vs_pop", 0, 1, 1, 1, 4'h5, 4'h0, 0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 5; i++) run_op("fill", 0, 0, 1, 0, 4'(i), 4'h0, 0);
    checks++;
    if ({sif.sp, sif.full, sif.overflow} !== {4'hB, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL overflow state: got %h expected %h", {sif.sp, sif.full, sif.overflow}, 6'h2F);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    run_op("pop_empty", 0, 0, 0, 1, 4'h0, 4'h0, 0);
    run_op("clear_err", 0, 0, 0, 0, 4'h0, 4'h0, 1);
    checks++;
    if (sif.underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow clear: got %b expected 0", sif.underflow);
    end
    run_op("set_wins", 0, 0, 0, 1, 4'h0, 4'h0, 1);
  endtask

  task automatic test_ret();
    apply_reset();
    run_op("push_7", 0, 0, 1, 0, 4'h7, 4'h0, 0);
    run_op("ret_7", 0, 1, 0, 0, 4'h0, 4'h0, 0);
    checks++;
    if (sif.empty !== 1'b1) begin
      failures++;
      $display("FAIL ret empty: got %b expected 1", sif.empty);
    end
  endtask

  task automatic test_reset_mid_wr();
    apply_reset();
    run_op("pre_push", 0, 0, 1, 0, 4'h4, 4'h0, 0);
    sif.push_req = 1'b1;
    sif.b_data   = 4'h9;
    @(negedge clk);
    sif.push_req = 1'b0;
    checks++;
    if (sif.ram_we !== 1'b1) begin
      failures++;
      $display("FAIL mid_wr we: got %b expected 1", sif.ram_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sif.ram_we, sif.busy, sif.sp, sif.count} !== {2'b00, 4'hF, 4'h0}) begin
      failures++;
      $display("FAIL mid_wr abort: got %h expected %h",
               {sif.ram_we, sif.busy, sif.sp, sif.count}, {2'b00, 4'hF, 4'h0});
    end
    @(negedge clk);
    reset = 1'b0;
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    run_op("after_abort", 0, 0, 0, 1, 4'h0, 4'h0, 0);
  endtask

  task automatic test_random();
    bit c, r, p, o, clr;
    apply_reset();
    for (int i = 0; i < 150; i++) begin
      c   = ($urandom % 100) < 15;
      r   = ($urandom % 100) < 15;
      p   = ($urandom % 100) < 50;
      o   = ($urandom % 100) < 45;
      clr = ($urandom % 100) < 10;
      run_op("random", c, r, p, o, 4'($urandom), 4'($urandom), clr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    sif.b_data  = 4'h0;
    sif.pc_data = 4'h0;
    @(negedge clk);
    test_reset();
    test_push_pop();
    test_priority();
    test_overflow();
    test_underflow();
    test_ret();
    test_reset_mid_wr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
